load_store_unit: RTL and testbench

- Sits between the RV32I core's memory stage and the synchronous data SRAM (one-cycle read latency), directly downstream of the core.
- Accepts one load/store request at a time over a valid/ready handshake.
- Generates word-aligned SRAM accesses with byte write strobes, and sign- or zero-extends sub-word load data.
- Returns a response with an error flag for misaligned or illegal accesses. The core stalls while req_ready is low.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response channel of the load/store unit.
// The core drives the request and the response acceptance; the unit drives the rest.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-aligned SRAM access with byte
// strobes, sub-word load extraction and extension, error response for bad accesses.
module load_store_unit #(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  cpu,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t            state_q, state_d;
   logic              accept;
   logic              req_err;
   logic [3:0]        strb_d;
   logic [31:0]       wdata_d;

   logic [2:0]        funct3_q;
   logic [1:0]        lane_q;
   logic              we_q;
   logic [3:0]        strb_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31-(MEM_AW+2):0] unused_addr_hi;
   assign unused_addr_hi = cpu.req_addr[31:MEM_AW+2];

   // Pick the addressed byte/halfword out of the SRAM word and extend it.
   function automatic logic [31:0] format_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    format_load = {{24{b[7]}}, b};
         F3_H:    format_load = {{16{h[15]}}, h};
         F3_BU:   format_load = {24'b0, b};
         F3_HU:   format_load = {16'b0, h};
         default: format_load = word;
      endcase
   endfunction

   assign accept = (state_q == IDLE) && cpu.req_valid;

   // NOTE: every always_comb output gets a default before the case so no latch is inferred.
   always_comb begin
      req_err = 1'b0;
      case (cpu.req_funct3)
         F3_B:    req_err = 1'b0;
         F3_H:    req_err = cpu.req_addr[0];
         F3_W:    req_err = |cpu.req_addr[1:0];
         F3_BU:   req_err = cpu.req_we;
         F3_HU:   req_err = cpu.req_we | cpu.req_addr[0];
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      strb_d  = 4'b1111;
      wdata_d = cpu.req_wdata;
      case (cpu.req_funct3[1:0])
         2'b00: begin
            strb_d  = 4'b0001 << cpu.req_addr[1:0];
            wdata_d = {4{cpu.req_wdata[7:0]}};
         end
         2'b01: begin
            strb_d  = cpu.req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{cpu.req_wdata[15:0]}};
         end
         default: begin
            strb_d  = 4'b1111;
            wdata_d = cpu.req_wdata;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cpu.req_valid) state_d = req_err ? RESP : ACCESS;
         ACCESS:  state_d = we_q ? RESP : WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (cpu.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         funct3_q    <= 3'b000;
         lane_q      <= 2'b00;
         we_q        <= 1'b0;
         strb_q      <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q <= cpu.req_funct3;
            lane_q   <= cpu.req_addr[1:0];
            we_q     <= cpu.req_we;
            rdata_q  <= 32'h0;
            err_q    <= req_err;
            // SRAM-side registers only move for requests that really reach the SRAM.
            if (!req_err) begin
               mem_addr_q <= cpu.req_addr[MEM_AW+1:2];
               strb_q     <= cpu.req_we ? strb_d : 4'b0000;
               if (cpu.req_we) mem_wdata_q <= wdata_d;
            end
         end
         if (state_q == WAIT) rdata_q <= format_load(mem_rdata, funct3_q, lane_q);
      end
   end

   assign cpu.req_ready = (state_q == IDLE);
   assign cpu.rsp_valid = (state_q == RESP);
   assign cpu.rsp_rdata = rdata_q;
   assign cpu.rsp_err   = err_q;
   assign mem_en        = (state_q == ACCESS);
   assign mem_we        = mem_en ? strb_q : 4'b0000;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-latency SRAM.
module tb_load_store_unit;
   localparam int MEM_AW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   load_store_unit #(.MEM_AW(MEM_AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (bus.slave),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // SRAM model; the preload port lets the bench seed words without a second writer.
   logic              pl_en;
   logic [MEM_AW-1:0] pl_addr;
   logic [31:0]       pl_data;
   logic [31:0]       sram [0:(1<<MEM_AW)-1];

   always @(posedge clk) begin
      if (pl_en) begin
         sram[pl_addr] <= pl_data;
      end else if (mem_en) begin
         if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
         for (int i = 0; i < 4; i++)
            if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'd0);
      check({tag, ".rsp_err"},   32'(bus.rsp_err), 32'd0);
      check({tag, ".mem_en"},    32'(mem_en), 32'd0);
      check({tag, ".mem_we"},    32'(mem_we), 32'd0);
      check({tag, ".mem_addr"},  32'(mem_addr), 32'd0);
      check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
   endtask

   // One full transaction: accept, measure latency and SRAM activity, optional
   // back-pressure in RESP, then the response handshake.
   task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input int exp_en_n,
                          input logic [MEM_AW-1:0] exp_maddr, input logic [3:0] exp_we,
                          input logic [31:0] exp_mwdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
      int lat;
      int en_n;
      int guard;
      logic [3:0]        seen_we;
      logic [MEM_AW-1:0] seen_addr;
      logic [31:0]       seen_wdata;

      @(negedge clk);
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = ~we;
      bus.req_funct3 = 3'b111;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_wdata  = 32'h5555_5555;

      lat        = 0;
      en_n       = 0;
      seen_we    = 4'b0000;
      seen_addr  = '0;
      seen_wdata = 32'h0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_en) begin
            en_n++;
            seen_we    = mem_we;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
         end
      end while (!bus.rsp_valid && lat < 20);

      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".mem_en_cycles"}, 32'(en_n), 32'(exp_en_n));
      if (exp_en_n > 0) begin
         check({tag, ".mem_addr"}, 32'(seen_addr), 32'(exp_maddr));
         check({tag, ".mem_we"}, 32'(seen_we), 32'(exp_we));
         if (exp_we != 4'b0000) check({tag, ".mem_wdata"}, seen_wdata, exp_mwdata);
      end
      check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold.rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, ".hold.rsp_rdata"}, bus.rsp_rdata, exp_rdata);
         check({tag, ".hold.rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
         check({tag, ".hold.req_ready"}, 32'(bus.req_ready), 32'd0);
      end

      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      check({tag, ".after.rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, ".after.req_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst            = 1'b1;
      pl_en          = 1'b0;
      pl_addr        = '0;
      pl_data        = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.rsp_ready  = 1'b0;

      preload(10'd3, 32'hABCD_EF11);
      preload(10'd4, 32'hFFFF_FFFF);
      preload(10'd5, 32'h1234_5678);
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Loads from word 3 = ABCDEF11
      run_req("lw12",  1'b0, 3'b010, 32'd12, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hABCD_EF11, 1'b0, 0);
      run_req("lb13",  1'b0, 3'b000, 32'd13, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hFFFF_FFEF, 1'b0, 0);
      run_req("lbu13", 1'b0, 3'b100, 32'd13, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'h0000_00EF, 1'b0, 0);
      run_req("lh14",  1'b0, 3'b001, 32'd14, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hFFFF_ABCD, 1'b0, 0);
      run_req("lhu14", 1'b0, 3'b101, 32'd14, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'h0000_ABCD, 1'b0, 0);

      // Stores into word 4 = FFFFFFFF, then a full-word store/load round trip
      run_req("sb17", 1'b1, 3'b000, 32'd17, 32'h0000_00AA, 2, 1, 10'd4, 4'b0010, 32'hAAAA_AAAA, 32'h0, 1'b0, 0);
      check("sb17.sram4", sram[4], 32'hFFFF_AAFF);
      run_req("sh18", 1'b1, 3'b001, 32'd18, 32'h0000_1234, 2, 1, 10'd4, 4'b1100, 32'h1234_1234, 32'h0, 1'b0, 0);
      check("sh18.sram4", sram[4], 32'h1234_AAFF);
      run_req("sw24", 1'b1, 3'b010, 32'd24, 32'hCAFE_BABE, 2, 1, 10'd6, 4'b1111, 32'hCAFE_BABE, 32'h0, 1'b0, 0);
      run_req("lw24", 1'b0, 3'b010, 32'd24, 32'h0, 3, 1, 10'd6, 4'b0000, 32'h0, 32'hCAFE_BABE, 1'b0, 0);

      // Misaligned and illegal accesses: one-cycle error, no SRAM traffic
      run_req("err_lw6",  1'b0, 3'b010, 32'd6,  32'h0,    1, 0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
      run_req("err_sh19", 1'b1, 3'b001, 32'd19, 32'h1234, 1, 0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
      run_req("err_f3_3", 1'b0, 3'b011, 32'd12, 32'h0,    1, 0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
      run_req("err_sbu",  1'b1, 3'b100, 32'd16, 32'hFF,   1, 0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 0);

      // Back-pressure in RESP, then back-to-back loads
      run_req("lw12_hold", 1'b0, 3'b010, 32'd12, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hABCD_EF11, 1'b0, 3);
      run_req("b2b_lw12",  1'b0, 3'b010, 32'd12, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hABCD_EF11, 1'b0, 0);
      run_req("b2b_lw20",  1'b0, 3'b010, 32'd20, 32'h0, 3, 1, 10'd5, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 0);

      // Asynchronous reset while a load sits in WAIT
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'd12;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_wait");
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      check("rst_wait.no_rsp", 32'(seen), 32'd0);
      run_req("post_rst_lw12", 1'b0, 3'b010, 32'd12, 32'h0, 3, 1, 10'd3, 4'b0000, 32'h0, 32'hABCD_EF11, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
